// File: rtl/doa_scan_ctrl_pkg.sv
// Shared constants and types for the DoA angle-sweep controller.
//   WORD_LENGTH : sample / steering word width (signed)
//   POW_WIDTH   : beamformer power word width (signed)
//   N_ANGLES    : number of steering vectors in the ROM
//   IDX_W       : angle index width
//   cvec4_t     : 4-element complex vector {I1,Q1,I2,Q2,I3,Q3,I4,Q4}, MSB first;
//                 also the ROM word layout of the steering image
//   state_t     : sweep FSM encoding
package doa_scan_ctrl_pkg;

   localparam int unsigned WORD_LENGTH = 16;
   localparam int unsigned POW_WIDTH   = (2*WORD_LENGTH+3)*2+1;
   localparam int unsigned N_ANGLES    = 181;
   localparam int unsigned IDX_W       = 8;
   localparam int unsigned VEC_W       = 8*WORD_LENGTH;

   typedef logic signed [WORD_LENGTH-1:0] word_t;
   typedef logic signed [POW_WIDTH-1:0]   pow_t;
   typedef logic        [IDX_W-1:0]       idx_t;

   typedef struct packed {
      word_t i1;
      word_t q1;
      word_t i2;
      word_t q2;
      word_t i3;
      word_t q3;
      word_t i4;
      word_t q4;
   } cvec4_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam idx_t LAST_IDX = IDX_W'(N_ANGLES-1);

endpackage

// File: rtl/doa_scan_ctrl_if.sv
// Signal bundle between the sweep controller, the sample front-end, the
// external power stage and the DoA result consumer.
//   slave  : the controller (doa_scan_ctrl)
//   master : the parent / environment driving start, snapshot and power_in
// Optional stream signals (pow_valid, pow_idx, pow_out) exist only when
// DOA_SCAN_STREAM_EN is defined.
interface doa_scan_ctrl_if;
   import doa_scan_ctrl_pkg::*;

   logic  start;
   word_t I_x1, I_x2, I_x3, I_x4;
   word_t Q_x1, Q_x2, Q_x3, Q_x4;
   word_t I_xo1, I_xo2, I_xo3, I_xo4;
   word_t Q_xo1, Q_xo2, Q_xo3, Q_xo4;
   word_t I_s1, I_s2, I_s3, I_s4;
   word_t Q_s1, Q_s2, Q_s3, Q_s4;
   pow_t  power_in;
   logic  busy;
   logic  done;
   idx_t  best_idx;
   pow_t  best_pow;
`ifdef DOA_SCAN_STREAM_EN
   logic  pow_valid;
   idx_t  pow_idx;
   pow_t  pow_out;
`endif

   modport slave (
      input  start, I_x1, I_x2, I_x3, I_x4, Q_x1, Q_x2, Q_x3, Q_x4, power_in,
      output I_xo1, I_xo2, I_xo3, I_xo4, Q_xo1, Q_xo2, Q_xo3, Q_xo4,
      output I_s1, I_s2, I_s3, I_s4, Q_s1, Q_s2, Q_s3, Q_s4,
      output busy, done, best_idx, best_pow
`ifdef DOA_SCAN_STREAM_EN
      , output pow_valid, pow_idx, pow_out
`endif
   );

   modport master (
      output start, I_x1, I_x2, I_x3, I_x4, Q_x1, Q_x2, Q_x3, Q_x4, power_in,
      input  I_xo1, I_xo2, I_xo3, I_xo4, Q_xo1, Q_xo2, Q_xo3, Q_xo4,
      input  I_s1, I_s2, I_s3, I_s4, Q_s1, Q_s2, Q_s3, Q_s4,
      input  busy, done, best_idx, best_pow
`ifdef DOA_SCAN_STREAM_EN
      , input pow_valid, pow_idx, pow_out
`endif
   );

endinterface

// File: rtl/doa_scan_ctrl_steer_rom.sv
// Steering-vector ROM: N_ANGLES words of cvec4_t, synchronous 1-cycle read.
//   clk, rst : clock, synchronous active-high reset (clears the read register)
//   en       : read enable; data holds when low
//   addr     : angle index
//   data     : registered steering vector
// ROM_FILE names the steering image; contents are preloaded into mem by the environment.
module doa_scan_ctrl_steer_rom
   import doa_scan_ctrl_pkg::*;
#(
   parameter string ROM_FILE = "steer.hex"
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   en,
   input  idx_t   addr,
   output cvec4_t data
);

   logic [VEC_W-1:0] mem [N_ANGLES];

   // registered read port
   always_ff @(posedge clk) begin
      if (rst)     data <= '0;
      else if (en) data <= cvec4_t'(mem[addr]);
   end

endmodule

// File: rtl/doa_scan_ctrl.sv
// DoA angle-sweep controller. Latches one array snapshot on start, plays
// every steering vector from the ROM into the external power stage, reads
// the power back one cycle later and reports the peak angle and power.
//   clk, rst : clock, synchronous active-high reset
//   bus      : doa_scan_ctrl_if.slave (start, snapshot in/out, steering out,
//              power_in, busy, done, best_idx, best_pow)
// Option DOA_SCAN_STREAM_EN: per-angle power stream (pow_valid/pow_idx/pow_out).
module doa_scan_ctrl
   import doa_scan_ctrl_pkg::*;
#(
   parameter string ROM_FILE = "steer.hex"
) (
   input  logic           clk,
   input  logic           rst,
   doa_scan_ctrl_if.slave bus
);

   state_t state, state_nxt;
   cvec4_t snap, steer;
   idx_t   rd_idx, cmp_idx, max_idx, best_idx;
   pow_t   max_pow, best_pow;
   logic   rd_act, cmp_vld, first, busy, done;
   logic   accept_c, rom_en_c, last_cmp_c, upd_c;

   assign accept_c   = (state == IDLE) && bus.start;
   assign rom_en_c   = (state == SCAN) && rd_act;
   assign last_cmp_c = cmp_vld && (cmp_idx == LAST_IDX);
   // strict '>' keeps the lower index on ties
   assign upd_c      = cmp_vld && (first || (bus.power_in > max_pow));

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SCAN;
         SCAN:    if (last_cmp_c) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // snapshot latch, address/compare pipeline, running max and results
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         snap     <= '0;
         rd_idx   <= '0;
         rd_act   <= 1'b0;
         cmp_idx  <= '0;
         cmp_vld  <= 1'b0;
         first    <= 1'b0;
         max_idx  <= '0;
         max_pow  <= '0;
         best_idx <= '0;
         best_pow <= '0;
      end else begin
         busy <= (state_nxt == SCAN);
         done <= (state_nxt == DONE);
         if (accept_c) begin
            snap    <= {bus.I_x1, bus.Q_x1, bus.I_x2, bus.Q_x2,
                        bus.I_x3, bus.Q_x3, bus.I_x4, bus.Q_x4};
            rd_idx  <= '0;
            rd_act  <= 1'b1;
            cmp_vld <= 1'b0;
            first   <= 1'b1;
            max_idx <= '0;
            max_pow <= '0;
         end else if (state == SCAN) begin
            // compare stage trails the ROM address by one cycle
            cmp_vld <= rd_act;
            cmp_idx <= rd_idx;
            if (rd_act) begin
               if (rd_idx == LAST_IDX) rd_act <= 1'b0;
               else                    rd_idx <= rd_idx + idx_t'(1);
            end
            if (upd_c) begin
               max_pow <= bus.power_in;
               max_idx <= cmp_idx;
               first   <= 1'b0;
            end
            // last compare folds straight into the published result
            if (last_cmp_c) begin
               best_idx <= upd_c ? cmp_idx      : max_idx;
               best_pow <= upd_c ? bus.power_in : max_pow;
            end
         end
      end
   end

   doa_scan_ctrl_steer_rom #(.ROM_FILE(ROM_FILE)) u_rom (
      .clk  (clk),
      .rst  (rst),
      .en   (rom_en_c),
      .addr (rd_idx),
      .data (steer)
   );

`ifdef DOA_SCAN_STREAM_EN
   // per-angle power stream, one cycle behind the compare
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.pow_valid <= 1'b0;
         bus.pow_idx   <= '0;
         bus.pow_out   <= '0;
      end else begin
         bus.pow_valid <= cmp_vld;
         if (cmp_vld) begin
            bus.pow_idx <= cmp_idx;
            bus.pow_out <= bus.power_in;
         end
      end
   end
`endif

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.best_idx = best_idx;
   assign bus.best_pow = best_pow;

   assign bus.I_xo1 = snap.i1;
   assign bus.Q_xo1 = snap.q1;
   assign bus.I_xo2 = snap.i2;
   assign bus.Q_xo2 = snap.q2;
   assign bus.I_xo3 = snap.i3;
   assign bus.Q_xo3 = snap.q3;
   assign bus.I_xo4 = snap.i4;
   assign bus.Q_xo4 = snap.q4;

   assign bus.I_s1 = steer.i1;
   assign bus.Q_s1 = steer.q1;
   assign bus.I_s2 = steer.i2;
   assign bus.Q_s2 = steer.q2;
   assign bus.I_s3 = steer.i3;
   assign bus.Q_s3 = steer.q3;
   assign bus.I_s4 = steer.i4;
   assign bus.Q_s4 = steer.q4;

endmodule

// File: tb/tb_doa_scan_ctrl.sv
// Bench for doa_scan_ctrl with a behavioural power stage |sum x_k*s_k|^2.
// Steering vectors sit on the radius-5000 circle {(5,0),(4,3),(3,4),...}*1000,
// element 1 fixed at phase 0, so a snapshot equal to conj(entry a) peaks
// uniquely at angle a with power (4*25e6)^2 = 1e16.
// Honours DOA_SCAN_STREAM_EN (checks the per-angle stream when defined).
module tb_doa_scan_ctrl;
   import doa_scan_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   doa_scan_ctrl_if bus();

   doa_scan_ctrl #(.ROM_FILE("")) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errs   = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- reference data ----------------
   function automatic word_t ph_re(input int p);
      case (p)
         0: return word_t'(5000);   1: return word_t'(4000);   2: return word_t'(3000);
         3: return word_t'(0);      4: return word_t'(-3000);  5: return word_t'(-4000);
         6: return word_t'(-5000);  7: return word_t'(-4000);  8: return word_t'(-3000);
         9: return word_t'(0);      10: return word_t'(3000);  11: return word_t'(4000);
         default: return word_t'(0);
      endcase
   endfunction

   function automatic word_t ph_im(input int p);
      case (p)
         0: return word_t'(0);      1: return word_t'(3000);   2: return word_t'(4000);
         3: return word_t'(5000);   4: return word_t'(4000);   5: return word_t'(3000);
         6: return word_t'(0);      7: return word_t'(-3000);  8: return word_t'(-4000);
         9: return word_t'(-5000);  10: return word_t'(-4000); 11: return word_t'(-3000);
         default: return word_t'(0);
      endcase
   endfunction

   function automatic cvec4_t steer_entry(input int a);
      int p2, p3, p4;
      p2 = a % 12;
      p3 = (a / 12) % 12;
      p4 = a / 144;
      return {ph_re(0), ph_im(0), ph_re(p2), ph_im(p2),
              ph_re(p3), ph_im(p3), ph_re(p4), ph_im(p4)};
   endfunction

   function automatic cvec4_t cj(input cvec4_t v);
      cvec4_t r;
      r = v;
      r.q1 = -v.q1; r.q2 = -v.q2; r.q3 = -v.q3; r.q4 = -v.q4;
      return r;
   endfunction

   function automatic cvec4_t div1000(input cvec4_t v);
      cvec4_t r;
      r.i1 = v.i1 / word_t'(1000); r.q1 = v.q1 / word_t'(1000);
      r.i2 = v.i2 / word_t'(1000); r.q2 = v.q2 / word_t'(1000);
      r.i3 = v.i3 / word_t'(1000); r.q3 = v.q3 / word_t'(1000);
      r.i4 = v.i4 / word_t'(1000); r.q4 = v.q4 / word_t'(1000);
      return r;
   endfunction

   function automatic pow_t pw(input cvec4_t x, input cvec4_t s);
      logic signed [34:0] re, im;
      re = 35'(x.i1)*35'(s.i1) - 35'(x.q1)*35'(s.q1) + 35'(x.i2)*35'(s.i2) - 35'(x.q2)*35'(s.q2)
         + 35'(x.i3)*35'(s.i3) - 35'(x.q3)*35'(s.q3) + 35'(x.i4)*35'(s.i4) - 35'(x.q4)*35'(s.q4);
      im = 35'(x.i1)*35'(s.q1) + 35'(x.q1)*35'(s.i1) + 35'(x.i2)*35'(s.q2) + 35'(x.q2)*35'(s.i2)
         + 35'(x.i3)*35'(s.q3) + 35'(x.q3)*35'(s.i3) + 35'(x.i4)*35'(s.q4) + 35'(x.q4)*35'(s.i4);
      return pow_t'(re)*pow_t'(re) + pow_t'(im)*pow_t'(im);
   endfunction

   // ---------------- behavioural power stage ----------------
   cvec4_t xo, so;
   assign xo = {bus.I_xo1, bus.Q_xo1, bus.I_xo2, bus.Q_xo2, bus.I_xo3, bus.Q_xo3, bus.I_xo4, bus.Q_xo4};
   assign so = {bus.I_s1, bus.Q_s1, bus.I_s2, bus.Q_s2, bus.I_s3, bus.Q_s3, bus.I_s4, bus.Q_s4};
   assign bus.power_in = pw(xo, so);

   task automatic set_x(input cvec4_t x);
      {bus.I_x1, bus.Q_x1, bus.I_x2, bus.Q_x2, bus.I_x3, bus.Q_x3, bus.I_x4, bus.Q_x4} = x;
   endtask

   // One sweep from IDLE; called #1 after a posedge. Optional start re-pulses
   // at cycles rep_a/rep_b and a reset at cycle rst_at (cycle 1 = first after start edge).
   task automatic sweep(input cvec4_t x, input int rep_a, input int rep_b, input int rst_at,
                        output int lat, output bit busy_ok, output bit rst_hit);
      int  cyc;
      int  n_str;
      bit  stop;
      lat = -1; busy_ok = 1'b1; rst_hit = 1'b0; stop = 1'b0; n_str = 0;
      set_x(x);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      set_x(~x);               // snapshot must already be latched
      cyc = 1;
      while (!stop && cyc <= 400) begin
`ifdef DOA_SCAN_STREAM_EN
         if (bus.pow_valid) begin
            chk("stream_idx", 128'(bus.pow_idx), 128'(n_str));
            chk("stream_pow", 128'(bus.pow_out), 128'(pw(x, steer_entry(n_str))));
            n_str++;
         end
`endif
         if (bus.done) begin
            lat = cyc;
            stop = 1'b1;
         end else begin
            if (!bus.busy) busy_ok = 1'b0;
            if (cyc == rst_at) begin
               rst = 1'b1;
               @(posedge clk); #1;
               rst = 1'b0;
               rst_hit = 1'b1;
               stop = 1'b1;
            end else begin
               bus.start = (cyc == rep_a) || (cyc == rep_b);
               @(posedge clk); #1;
               bus.start = 1'b0;
               cyc++;
            end
         end
      end
`ifdef DOA_SCAN_STREAM_EN
      if (!rst_hit) chk("stream_count", 128'(n_str), 128'(N_ANGLES));
`endif
      bus.start = 1'b0;
   endtask

   // Idle for n cycles; count any done pulse or busy level.
   task automatic watch_quiet(input int n, output int bad);
      bad = 0;
      for (int i = 0; i < n; i++) begin
         if (bus.done || bus.busy) bad++;
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      string  name;
      cvec4_t x;
      int     exp_idx;
      pow_t   exp_pow;
   } vec_t;

   vec_t   tbl[6];
   int     lat;
   int     bad;
   bit     busy_ok;
   bit     rst_hit;
   cvec4_t x60, x1;

   initial begin
      rst = 1'b1;
      bus.start = 1'b0;
      set_x('0);
      for (int a = 0; a < int'(N_ANGLES); a++) dut.u_rom.mem[a] = steer_entry(a);

      x60 = cj(steer_entry(60));
      x1  = '0;
      x1.i1 = word_t'(1);
      tbl[0] = '{name: "matched60",  x: x60,                     exp_idx: 60,  exp_pow: pow_t'(64'd10000000000000000)};
      tbl[1] = '{name: "zero",       x: '0,                      exp_idx: 0,   exp_pow: pow_t'(0)};
      tbl[2] = '{name: "matched0",   x: cj(steer_entry(0)),      exp_idx: 0,   exp_pow: pow_t'(64'd10000000000000000)};
      tbl[3] = '{name: "matched180", x: cj(steer_entry(180)),    exp_idx: 180, exp_pow: pow_t'(64'd10000000000000000)};
      tbl[4] = '{name: "scaled60",   x: div1000(x60),            exp_idx: 60,  exp_pow: pow_t'(64'd10000000000)};
      tbl[5] = '{name: "tie_elem1",  x: x1,                      exp_idx: 0,   exp_pow: pow_t'(25000000)};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",     128'(bus.busy),     128'(0));
      chk("rst_done",     128'(bus.done),     128'(0));
      chk("rst_best_idx", 128'(bus.best_idx), 128'(0));
      chk("rst_best_pow", 128'(bus.best_pow), 128'(0));
      chk("rst_I_xo1",    128'(bus.I_xo1),    128'(0));
      chk("rst_Q_xo4",    128'(bus.Q_xo4),    128'(0));
      chk("rst_I_s1",     128'(bus.I_s1),     128'(0));
      chk("rst_Q_s4",     128'(bus.Q_s4),     128'(0));
`ifdef DOA_SCAN_STREAM_EN
      chk("rst_pow_valid", 128'(bus.pow_valid), 128'(0));
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // table-driven sweeps
      for (int t = 0; t < 6; t++) begin
         sweep(tbl[t].x, -1, -1, -1, lat, busy_ok, rst_hit);
         chk({tbl[t].name, "_latency"},  128'(lat),          128'(183));
         chk({tbl[t].name, "_busy"},     128'(busy_ok),      128'(1));
         chk({tbl[t].name, "_best_idx"}, 128'(bus.best_idx), 128'(tbl[t].exp_idx));
         chk({tbl[t].name, "_best_pow"}, 128'(bus.best_pow), 128'(tbl[t].exp_pow));
         chk({tbl[t].name, "_I_xo3"},    128'(bus.I_xo3),    128'(tbl[t].x.i3));
         chk({tbl[t].name, "_Q_xo3"},    128'(bus.Q_xo3),    128'(tbl[t].x.q3));
         chk({tbl[t].name, "_I_s4"},     128'(bus.I_s4),     128'(word_t'(4000)));
         chk({tbl[t].name, "_Q_s3"},     128'(bus.Q_s3),     128'(word_t'(5000)));
         @(posedge clk); #1;
         chk({tbl[t].name, "_done_1cyc"}, 128'(bus.done),     128'(0));
         chk({tbl[t].name, "_idx_hold"},  128'(bus.best_idx), 128'(tbl[t].exp_idx));
      end

      // start re-pulsed mid-sweep is ignored and not queued
      sweep(x60, 10, 100, -1, lat, busy_ok, rst_hit);
      chk("repulse_latency",  128'(lat),          128'(183));
      chk("repulse_busy",     128'(busy_ok),      128'(1));
      chk("repulse_best_idx", 128'(bus.best_idx), 128'(60));
      @(posedge clk); #1;
      watch_quiet(200, bad);
      chk("repulse_no_queue", 128'(bad), 128'(0));

      // reset mid-sweep, then a normal sweep
      sweep(cj(steer_entry(180)), -1, -1, 50, lat, busy_ok, rst_hit);
      chk("midrst_hit",      128'(rst_hit),      128'(1));
      chk("midrst_busy_ok",  128'(busy_ok),      128'(1));
      chk("midrst_busy",     128'(bus.busy),     128'(0));
      chk("midrst_done",     128'(bus.done),     128'(0));
      chk("midrst_best_idx", 128'(bus.best_idx), 128'(0));
      chk("midrst_best_pow", 128'(bus.best_pow), 128'(0));
      chk("midrst_I_xo1",    128'(bus.I_xo1),    128'(0));
      watch_quiet(200, bad);
      chk("midrst_quiet",    128'(bad), 128'(0));
      sweep(x60, -1, -1, -1, lat, busy_ok, rst_hit);
      chk("after_rst_latency",  128'(lat),          128'(183));
      chk("after_rst_best_idx", 128'(bus.best_idx), 128'(60));
      chk("after_rst_best_pow", 128'(bus.best_pow), 128'(pow_t'(64'd10000000000000000)));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
